sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/axis_stepper.sv | 49 ++++
 rtl/sprite_motion_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and defaults for the sprite motion controller.
//   POS_W               : width of every pixel coordinate (11 bits, 0..2047)
//   DEFAULT_H_MAX       : default visible width in pixels
//   DEFAULT_V_MAX       : default visible height in pixels
//   DEFAULT_SPRITE_SIZE : default square sprite edge in pixels
//   shot_state_t        : projectile state machine encoding
//   clamp_pos()         : saturate a coordinate to an upper limit
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int POS_W               = 11;
    localparam int DEFAULT_H_MAX       = 640;
    localparam int DEFAULT_V_MAX       = 480;
    localparam int DEFAULT_SPRITE_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } shot_state_t;

    // Coordinates are unsigned, so only the upper bound needs saturating.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] value,
        input logic [POS_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// ---------------------------------------------------------------------------
// axis_stepper
// Purely combinational single-axis motion step: clamps the requested target
// to [0, MAX_POS], then moves the current position STEP pixels towards it
// unless the remaining distance lies inside the deadzone band.
// Ports:
//   target   in  POS_W  requested position (unsigned, may exceed MAX_POS)
//   pos      in  POS_W  current registered position
//   pos_step out POS_W  position to adopt if this frame applies motion
// ---------------------------------------------------------------------------
module axis_stepper
    import sprite_pkg::*;
#(
    parameter int MAX_POS  = 608,
    parameter int STEP     = 4,
    parameter int DEADZONE = 8
) (
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] pos_step
);

    localparam logic [POS_W-1:0] MAX_POS_V  = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] STEP_V     = POS_W'(STEP);
    localparam logic [POS_W-1:0] DEADZONE_V = POS_W'(DEADZONE);

    logic [POS_W-1:0] clamped;
    logic [POS_W-1:0] diff;

    always_comb begin
        clamped  = clamp_pos(target, MAX_POS_V);
        diff     = '0;
        pos_step = pos;
        if (clamped > pos) begin
            diff = clamped - pos;
            // Distances are computed as magnitudes so nothing can wrap; the
            // final min() stops a short remaining distance from overshooting.
            if (diff > DEADZONE_V) begin
                pos_step = (diff > STEP_V) ? pos + STEP_V : clamped;
            end
        end else begin
            diff = pos - clamped;
            if (diff > DEADZONE_V) begin
                pos_step = (diff > STEP_V) ? pos - STEP_V : clamped;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl
// Frame-rate sprite mover with a single projectile. Once per frame_tick the
// sprite steps toward the joystick target on both axes, and the projectile
// state machine (IDLE -> FLY -> COOLDOWN -> IDLE) advances. Every output is
// a register, so there is no combinational input-to-output path.
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous active-high reset
//   frame_tick   in   1      one-cycle pulse per video frame
//   target_x/y   in   11     scaled joystick position
//   fire         in   1      one-cycle debounced fire pulse
//   sprite_x/y   out  11     sprite top-left corner
//   shot_x/y     out  11     projectile position
//   shot_active  out  1      projectile visible
//   shot_fired   out  1      one-cycle pulse when a projectile spawns
// ---------------------------------------------------------------------------
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int H_MAX           = DEFAULT_H_MAX,
    parameter int V_MAX           = DEFAULT_V_MAX,
    parameter int SPRITE_SIZE     = DEFAULT_SPRITE_SIZE,
    parameter int STEP            = 4,
    parameter int DEADZONE        = 8,   // keep >= STEP so a step never overshoots
    parameter int SHOT_SPEED      = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] target_x,
    input  logic [POS_W-1:0] target_y,
    input  logic             fire,
    output logic [POS_W-1:0] sprite_x,
    output logic [POS_W-1:0] sprite_y,
    output logic [POS_W-1:0] shot_x,
    output logic [POS_W-1:0] shot_y,
    output logic             shot_active,
    output logic             shot_fired
);

    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 2);

    localparam logic [POS_W-1:0] X_HOME     = POS_W'((H_MAX - SPRITE_SIZE) / 2);
    localparam logic [POS_W-1:0] Y_HOME     = POS_W'((V_MAX - SPRITE_SIZE) / 2);
    localparam logic [POS_W-1:0] HALF_SIZE  = POS_W'(SPRITE_SIZE / 2);
    localparam logic [POS_W-1:0] SPEED_V    = POS_W'(SHOT_SPEED);
    localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COOLDOWN_FRAMES);

    // Axis 0 is X, axis 1 is Y.
    logic [POS_W-1:0] target_vec [2];
    logic [POS_W-1:0] step_pos   [2];
    logic [POS_W-1:0] pos_reg    [2];
    logic [POS_W-1:0] pos_next   [2];

    shot_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [POS_W-1:0] shot_x_reg, shot_x_next;
    logic [POS_W-1:0] shot_y_reg, shot_y_next;
    logic             shot_active_reg, shot_active_next;
    logic             shot_fired_reg, shot_fired_next;
    logic             fire_pending_reg, fire_pending_next;
    logic             fire_now;

    assign target_vec[0] = target_x;
    assign target_vec[1] = target_y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int AXIS_MAX = (gi == 0) ? (H_MAX - SPRITE_SIZE)
                                                : (V_MAX - SPRITE_SIZE);
            axis_stepper #(
                .MAX_POS  (AXIS_MAX),
                .STEP     (STEP),
                .DEADZONE (DEADZONE)
            ) u_axis (
                .target   (target_vec[gi]),
                .pos      (pos_reg[gi]),
                .pos_step (step_pos[gi])
            );
        end
    endgenerate

    // A fire pulse landing on the tick cycle itself belongs to that frame.
    assign fire_now = fire_pending_reg | fire;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        shot_x_next       = shot_x_reg;
        shot_y_next       = shot_y_reg;
        shot_active_next  = shot_active_reg;
        shot_fired_next   = 1'b0;
        fire_pending_next = fire_now;
        pos_next          = pos_reg;

        if (frame_tick) begin
            // Pending fire never survives a tick, so presses made while the
            // shot is busy are simply dropped.
            fire_pending_next = 1'b0;
            pos_next[0]       = step_pos[0];
            pos_next[1]       = step_pos[1];

            unique case (state_reg)
                IDLE: begin
                    if (fire_now) begin
                        state_next       = FLY;
                        // Spawn from the sprite position before this frame's move.
                        shot_x_next      = pos_reg[0] + HALF_SIZE;
                        shot_y_next      = pos_reg[1];
                        shot_active_next = 1'b1;
                        shot_fired_next  = 1'b1;
                    end
                end
                FLY: begin
                    if (shot_y_reg < SPEED_V) begin
                        state_next       = COOLDOWN;
                        shot_active_next = 1'b0;
                        cnt_next         = CD_LOAD;
                    end else begin
                        shot_y_next = shot_y_reg - SPEED_V;
                    end
                end
                COOLDOWN: begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_reg[0]       <= X_HOME;
            pos_reg[1]       <= Y_HOME;
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            shot_x_reg       <= '0;
            shot_y_reg       <= '0;
            shot_active_reg  <= 1'b0;
            shot_fired_reg   <= 1'b0;
            fire_pending_reg <= 1'b0;
        end else begin
            pos_reg          <= pos_next;
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            shot_x_reg       <= shot_x_next;
            shot_y_reg       <= shot_y_next;
            shot_active_reg  <= shot_active_next;
            shot_fired_reg   <= shot_fired_next;
            fire_pending_reg <= fire_pending_next;
        end
    end

    assign sprite_x    = pos_reg[0];
    assign sprite_y    = pos_reg[1];
    assign shot_x      = shot_x_reg;
    assign shot_y      = shot_y_reg;
    assign shot_active = shot_active_reg;
    assign shot_fired  = shot_fired_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Directed stimulus pushes the expected register image into a scoreboard
// queue; a monitor pops and compares on the cycle after each frame_tick or
// probe request, when the DUT presents its updated (or held) outputs.
// ---------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

    typedef struct {
        logic [10:0] sx;
        logic [10:0] sy;
        logic [10:0] hx;
        logic [10:0] hy;
        logic        act;
        logic        fired;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic [10:0] target_x;
    logic [10:0] target_y;
    logic        fire;
    logic [10:0] sprite_x;
    logic [10:0] sprite_y;
    logic [10:0] shot_x;
    logic [10:0] shot_y;
    logic        shot_active;
    logic        shot_fired;

    logic        probe;
    logic        strobe_d;
    exp_t        sb [$];
    int          checks;
    int          failures;
    int          txn;

    sprite_motion_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .target_x    (target_x),
        .target_y    (target_y),
        .fire        (fire),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_active (shot_active),
        .shot_fired  (shot_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int sx, input int sy, input int hx,
                                input int hy, input bit act, input bit fired);
        exp_t e;
        e.sx    = 11'(sx);
        e.sy    = 11'(sy);
        e.hx    = 11'(hx);
        e.hy    = 11'(hy);
        e.act   = act;
        e.fired = fired;
        return e;
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL txn=%0d %s got=%0d expected=%0d", txn, name, got, want);
        end
    endtask

    // Monitor: the DUT presents a new (or held) image the cycle after a
    // frame_tick or probe request was sampled.
    always @(posedge clk) strobe_d <= frame_tick | probe;

    always @(negedge clk) begin
        if (strobe_d) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL txn=%0d scoreboard got=empty expected=entry", txn);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sprite_x", sprite_x, e.sx);
                chk("sprite_y", sprite_y, e.sy);
                chk("shot_x", shot_x, e.hx);
                chk("shot_y", shot_y, e.hy);
                chk("shot_active", {10'd0, shot_active}, {10'd0, e.act});
                chk("shot_fired", {10'd0, shot_fired}, {10'd0, e.fired});
                $display("txn %0d: sprite=(%0d,%0d) shot=(%0d,%0d) act=%0b fired=%0b",
                         txn, sprite_x, sprite_y, shot_x, shot_y, shot_active, shot_fired);
            end
            txn++;
        end
    end

    task automatic step(input bit ft, input bit fr, input bit rst, input bit pr);
        frame_tick = ft;
        fire       = fr;
        reset      = rst;
        probe      = pr;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        fire       = 1'b0;
        reset      = 1'b0;
        probe      = 1'b0;
    endtask

    task automatic expect_tick(input bit fr, input exp_t e);
        sb.push_back(e);
        step(1'b1, fr, 1'b0, 1'b0);
    endtask

    task automatic expect_probe(input exp_t e);
        sb.push_back(e);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        txn        = 0;
        strobe_d   = 1'b0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        fire       = 1'b0;
        probe      = 1'b0;
        target_x   = 11'd304;
        target_y   = 11'd224;
        @(posedge clk);
        #1;

        // Reset state, and nothing moves without frame_tick even with a far target.
        do_reset();
        target_x = 11'd600;
        for (int i = 0; i < 4; i++) begin
            repeat (24) step(1'b0, 1'b0, 1'b0, 1'b0);
            expect_probe(mk(304, 224, 0, 0, 0, 0));
        end

        // Steady approach to the right, one step per tick.
        for (int k = 1; k <= 10; k++) begin
            expect_tick(1'b0, mk(304 + 4 * k, 224, 0, 0, 0, 0));
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        expect_probe(mk(344, 224, 0, 0, 0, 0));

        // Over-range target clamps to 608; motion halts once within 8 of it (600).
        target_x = 11'd2047;
        for (int k = 1; k <= 64; k++) expect_tick(1'b0, mk(344 + 4 * k, 224, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) expect_tick(1'b0, mk(600, 224, 0, 0, 0, 0));

        // Upward motion on Y.
        target_y = 11'd0;
        expect_tick(1'b0, mk(600, 220, 0, 0, 0, 0));
        expect_tick(1'b0, mk(600, 216, 0, 0, 0, 0));

        // Deadzone boundaries.
        do_reset();
        target_x = 11'd310;
        target_y = 11'd224;
        for (int k = 0; k < 5; k++) expect_tick(1'b0, mk(304, 224, 0, 0, 0, 0));
        target_x = 11'd296;   // diff -8: inside the band
        expect_tick(1'b0, mk(304, 224, 0, 0, 0, 0));
        target_x = 11'd295;   // diff -9: one step, then diff -5 holds
        expect_tick(1'b0, mk(300, 224, 0, 0, 0, 0));
        expect_tick(1'b0, mk(300, 224, 0, 0, 0, 0));
        target_y = 11'd233;   // diff +9
        expect_tick(1'b0, mk(300, 228, 0, 0, 0, 0));
        expect_tick(1'b0, mk(300, 228, 0, 0, 0, 0));

        // Shot lifecycle with fire hammered every frame.
        do_reset();
        target_x = 11'd304;
        target_y = 11'd224;
        step(1'b0, 1'b1, 1'b0, 1'b0);   // fire held pending across idle cycles
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_tick(1'b0, mk(304, 224, 320, 224, 1, 1));
        expect_probe(mk(304, 224, 320, 224, 1, 0));
        for (int k = 1; k <= 28; k++) expect_tick(1'b1, mk(304, 224, 320, 224 - 8 * k, 1, 0));
        expect_tick(1'b1, mk(304, 224, 320, 0, 0, 0));   // expiry
        for (int k = 1; k <= 16; k++) expect_tick(1'b1, mk(304, 224, 320, 0, 0, 0));
        expect_tick(1'b1, mk(304, 224, 320, 224, 1, 1)); // 17th tick after expiry spawns

        // Sprite moves while shot_x stays put.
        target_x = 11'd600;
        for (int k = 1; k <= 3; k++) expect_tick(1'b0, mk(304 + 4 * k, 224, 320, 224 - 8 * k, 1, 0));

        // Reset with a coincident frame_tick during flight wins.
        sb.push_back(mk(304, 224, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b1, 1'b0);
        expect_probe(mk(304, 224, 0, 0, 0, 0));
        // Back in IDLE: a fire on the next tick spawns from the home position.
        expect_tick(1'b1, mk(308, 224, 320, 224, 1, 1));

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
